l2_controller: RTL and testbench
================================

L2_CONTROLLER -- requirements
Module: L2_controller

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 nrst  input  1  reset, synchronous, active-high: 1 at a rising edge resets the block.
REQ-003 addr_L1_L2  input  64  line address from L1: tag [63:14], index [13:6], offset [5:0] ignored.
REQ-004 read_L1_L2  input  1  L1 line-read request; held high until ready_L2_L1 is sampled high.
REQ-005 write_L1_L2  input  1  L1 dirty-line writeback request; same hold rule.
REQ-006 ready_L2_L1  output  1  one-cycle completion pulse to L1.
REQ-007 read_L2_MEM  output  1  line-fetch request to memory.
REQ-008 write_L2_MEM  output  1  victim writeback request to memory.
REQ-009 addr_L2_MEM  output  64  memory line address, offset bits 0.
REQ-010 ready_MEM_L2  input  1  memory completion; a request is done when sampled high.
REQ-011 refill  output  1  one-cycle strobe: load memory line into the L2 data array at index_L2.
REQ-012 update  output  1  one-cycle strobe: write the L1 line into the L2 data array at index_L2.
REQ-013 index_L2  output  8  latched set index of the current request.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 hit_cnt, miss_cnt  output  32 each  saturating hit/miss counters.

Function
REQ-016 Direct-mapped, 256 sets; per set a 50-bit tag, a valid bit and a dirty bit, held in registers.
REQ-017 States: IDLE, COMPARE, WRITEBACK, ALLOCATE, FILL, UPDATE, RESPOND; all outputs are Moore-decoded from state and latched registers.
REQ-018 IDLE: when read_L1_L2 or write_L1_L2 is sampled high, latch the address, the op (write has priority if both are high) and index_L2, then go to COMPARE.
REQ-019 COMPARE (one cycle): hit = valid[idx] and stored tag == latched tag; hit_cnt or miss_cnt increments by 1 on exit, saturating at 0xFFFFFFFF.
REQ-020 Read hit -> RESPOND; write hit -> UPDATE.
REQ-021 Miss with victim valid and dirty -> WRITEBACK, for both ops.
REQ-022 Otherwise: read miss -> ALLOCATE; write miss -> UPDATE, with no fetch because L1 supplies the full line.
REQ-023 WRITEBACK: write_L2_MEM=1 and addr_L2_MEM={victim tag, idx, 6'b0}.
REQ-024 WRITEBACK exit: on ready_MEM_L2 sampled high, clear dirty[idx], then go to ALLOCATE (read) or UPDATE (write).
REQ-025 ALLOCATE: read_L2_MEM=1 and addr_L2_MEM={latched tag, idx, 6'b0}; on ready_MEM_L2 sampled high -> FILL.
REQ-026 FILL (one cycle): refill=1; on exit tag[idx]=latched tag, valid=1, dirty=0 -> RESPOND.
REQ-027 UPDATE (one cycle): update=1; on exit tag[idx]=latched tag, valid=1, dirty=1 -> RESPOND.
REQ-028 RESPOND (one cycle): ready_L2_L1=1, then IDLE.
REQ-029 No request is accepted in RESPOND, so a new request can be accepted at the earliest in the first IDLE cycle.
REQ-030 addr_L2_MEM is 0 outside WRITEBACK/ALLOCATE, and read_L2_MEM/write_L2_MEM are never high together.
REQ-031 Latency, counted from the edge that samples the request (edge 0): ready_L2_L1 high after edge 2 on a read hit and after edge 3 on a write hit or clean write miss.
REQ-032 Memory waits extend latency by the number of cycles spent in WRITEBACK and ALLOCATE.
REQ-033 ready_MEM_L2 is ignored outside WRITEBACK/ALLOCATE.
REQ-034 L1 request inputs are ignored outside IDLE.

Reset
REQ-035 nrst=1 at any edge, including mid-operation: state=IDLE, all valid and dirty bits=0, counters=0, index_L2=0, all outputs 0.
REQ-036 Any in-flight memory request is dropped without completion.
REQ-037 Tag array contents are don't-care after reset.

Verification
REQ-038 After reset, read 0x0000_0000_0000_4040 with memory ready after 3 cycles -> read_L2_MEM for 3 cycles at 0x...4040, refill pulse with index_L2=0x01, ready_L2_L1 pulse, miss_cnt=1.
REQ-039 Repeat the same read -> ready_L2_L1 exactly 2 cycles after the request is sampled, no memory activity, hit_cnt=1.
REQ-040 Write 0x...4040 (hit) -> update pulse, dirty[1]=1; then read 0x...8040 (same index, different tag) -> write_L2_MEM at 0x...4040, then read_L2_MEM at 0x...8040, refill, ready_L2_L1.
REQ-041 read_L1_L2 and write_L1_L2 high together -> treated as a write (update pulse, no refill).
REQ-042 Assert nrst while in ALLOCATE -> next cycle all outputs 0, busy=0; a subsequent read of the same address misses.
REQ-043 Preload miss_cnt at 0xFFFFFFFF (force) and issue a miss -> miss_cnt stays 0xFFFFFFFF.

Source files
------------

// File: rtl/l2_controller_if.sv
// L1-side and memory-side signal bundle for the L2 controller.
// slave: controller view; master: the surrounding L1/memory environment.
interface l2_controller_if;
  logic [63:0] addr_L1_L2;
  logic        read_L1_L2;
  logic        write_L1_L2;
  logic        ready_L2_L1;
  logic        read_L2_MEM;
  logic        write_L2_MEM;
  logic [63:0] addr_L2_MEM;
  logic        ready_MEM_L2;
  logic        refill;
  logic        update;
  logic [7:0]  index_L2;
  logic        busy;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  modport slave (
    input  addr_L1_L2, read_L1_L2, write_L1_L2, ready_MEM_L2,
    output ready_L2_L1, read_L2_MEM, write_L2_MEM, addr_L2_MEM,
           refill, update, index_L2, busy, hit_cnt, miss_cnt
  );

  modport master (
    output addr_L1_L2, read_L1_L2, write_L1_L2, ready_MEM_L2,
    input  ready_L2_L1, read_L2_MEM, write_L2_MEM, addr_L2_MEM,
           refill, update, index_L2, busy, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/l2_controller.sv
// Direct-mapped 256-set L2 tag/state controller with write-back victims and write-allocate-without-fetch.
// Read hit responds 2 edges after request sampling; memory waits add their cycle count; one request at a time.
module l2_controller (
  input  logic           clk,
  input  logic           nrst,
  l2_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, COMPARE, WRITEBACK, ALLOCATE, FILL, UPDATE, RESPOND
  } state_t;

  state_t      state, state_nxt;
  logic [49:0] tag_q;
  logic [7:0]  idx_q;
  logic        wr_q;
  logic [49:0] tag_arr [256];
  logic [255:0] valid_arr;
  logic [255:0] dirty_arr;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic        hit;
  logic        victim_dirty;
  logic        offset_unused;

  assign hit           = valid_arr[idx_q] && (tag_arr[idx_q] == tag_q);
  assign victim_dirty  = valid_arr[idx_q] && dirty_arr[idx_q];
  assign offset_unused = ^bus.addr_L1_L2[5:0];

  always_comb begin
    state_nxt        = state;
    bus.ready_L2_L1  = 1'b0;
    bus.read_L2_MEM  = 1'b0;
    bus.write_L2_MEM = 1'b0;
    bus.addr_L2_MEM  = 64'd0;
    bus.refill       = 1'b0;
    bus.update       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.read_L1_L2 || bus.write_L1_L2) state_nxt = COMPARE;
      end
      COMPARE: begin
        if (hit)               state_nxt = wr_q ? UPDATE : RESPOND;
        else if (victim_dirty) state_nxt = WRITEBACK;
        else                   state_nxt = wr_q ? UPDATE : ALLOCATE;
      end
      WRITEBACK: begin
        bus.write_L2_MEM = 1'b1;
        bus.addr_L2_MEM  = {tag_arr[idx_q], idx_q, 6'b0};
        if (bus.ready_MEM_L2) state_nxt = wr_q ? UPDATE : ALLOCATE;
      end
      ALLOCATE: begin
        bus.read_L2_MEM = 1'b1;
        bus.addr_L2_MEM = {tag_q, idx_q, 6'b0};
        if (bus.ready_MEM_L2) state_nxt = FILL;
      end
      FILL: begin
        bus.refill = 1'b1;
        state_nxt  = RESPOND;
      end
      UPDATE: begin
        bus.update = 1'b1;
        state_nxt  = RESPOND;
      end
      RESPOND: begin
        bus.ready_L2_L1 = 1'b1;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state      <= IDLE;
      tag_q      <= '0;
      idx_q      <= '0;
      wr_q       <= 1'b0;
      valid_arr  <= '0;
      dirty_arr  <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          // write wins when L1 raises both requests together
          if (bus.read_L1_L2 || bus.write_L1_L2) begin
            tag_q <= bus.addr_L1_L2[63:14];
            idx_q <= bus.addr_L1_L2[13:6];
            wr_q  <= bus.write_L1_L2;
          end
        end
        COMPARE: begin
          if (hit) begin
            if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
          end else begin
            if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
          end
        end
        WRITEBACK: begin
          if (bus.ready_MEM_L2) dirty_arr[idx_q] <= 1'b0;
        end
        FILL: begin
          valid_arr[idx_q] <= 1'b1;
          dirty_arr[idx_q] <= 1'b0;
        end
        UPDATE: begin
          valid_arr[idx_q] <= 1'b1;
          dirty_arr[idx_q] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Tags need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (!nrst && (state == FILL || state == UPDATE)) tag_arr[idx_q] <= tag_q;
  end

  assign bus.index_L2 = idx_q;
  assign bus.busy     = (state != IDLE);
  assign bus.hit_cnt  = hit_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_l2_controller.sv
// Randomized scoreboard bench for l2_controller against a set-level cache model.
module tb_l2_controller;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  l2_controller_if bus ();
  l2_controller dut (.clk(clk), .nrst(nrst), .bus(bus));

  typedef struct {
    bit          wr;
    bit          wb;
    logic [63:0] wb_addr;
    bit          alloc;
    logic [63:0] alloc_addr;
    logic [7:0]  idx;
    int          lat;
    logic [31:0] hcnt;
    logic [31:0] mcnt;
  } exp_t;

  exp_t sb_q[$];

  bit [49:0] m_tag   [256];
  bit        m_valid [256];
  bit        m_dirty [256];
  logic [31:0] m_hit, m_miss;

  int checks = 0;
  int errors = 0;
  int mem_delay = 1;
  bit mem_noise = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hit  = '0;
    m_miss = '0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"},  64'(bus.ready_L2_L1),  64'd0);
    chk({tag, "_rdmem"},  64'(bus.read_L2_MEM),  64'd0);
    chk({tag, "_wrmem"},  64'(bus.write_L2_MEM), 64'd0);
    chk({tag, "_addr"},   bus.addr_L2_MEM,       64'd0);
    chk({tag, "_refill"}, 64'(bus.refill),       64'd0);
    chk({tag, "_update"}, 64'(bus.update),       64'd0);
    chk({tag, "_index"},  64'(bus.index_L2),     64'd0);
    chk({tag, "_busy"},   64'(bus.busy),         64'd0);
    chk({tag, "_hitcnt"}, 64'(bus.hit_cnt),      64'd0);
    chk({tag, "_misscnt"},64'(bus.miss_cnt),     64'd0);
  endtask

  // Memory: completes each request after mem_delay cycles; idle-time noise on ready when enabled.
  int       mem_cnt = 0;
  bit [1:0] mem_prev = 2'b00;
  always @(negedge clk) begin
    if (bus.read_L2_MEM || bus.write_L2_MEM) begin
      if ({bus.read_L2_MEM, bus.write_L2_MEM} != mem_prev) mem_cnt = 0;
      mem_prev = {bus.read_L2_MEM, bus.write_L2_MEM};
      mem_cnt++;
      bus.ready_MEM_L2 = (mem_cnt >= mem_delay);
    end else begin
      mem_cnt  = 0;
      mem_prev = 2'b00;
      bus.ready_MEM_L2 = mem_noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Monitor: accumulates what the DUT does during one request, compares on ready_L2_L1.
  int          mon_lat, n_ref, n_upd;
  bit          saw_wb, saw_alloc, both_hi, addr_stray;
  logic [63:0] wb_a, al_a;
  logic [7:0]  strobe_idx;
  exp_t        e;
  always @(negedge clk) begin
    if (!bus.busy) begin
      mon_lat = 0; n_ref = 0; n_upd = 0;
      saw_wb = 0; saw_alloc = 0; both_hi = 0; addr_stray = 0;
    end else begin
      mon_lat++;
      if (bus.read_L2_MEM && bus.write_L2_MEM) both_hi = 1;
      if (!bus.read_L2_MEM && !bus.write_L2_MEM && bus.addr_L2_MEM != 64'd0) addr_stray = 1;
      if (bus.write_L2_MEM && !saw_wb) begin saw_wb = 1; wb_a = bus.addr_L2_MEM; end
      if (bus.read_L2_MEM && !saw_alloc) begin saw_alloc = 1; al_a = bus.addr_L2_MEM; end
      if (bus.refill) n_ref++;
      if (bus.update) n_upd++;
      if (bus.refill || bus.update) strobe_idx = bus.index_L2;
      if (bus.ready_L2_L1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got ready with empty scoreboard at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          chk("latency",     64'(mon_lat),   64'(e.lat));
          chk("writeback",   64'(saw_wb),    64'(e.wb));
          if (e.wb) chk("wb_addr", wb_a, e.wb_addr);
          chk("allocate",    64'(saw_alloc), 64'(e.alloc));
          if (e.alloc) chk("alloc_addr", al_a, e.alloc_addr);
          chk("refill_cnt",  64'(n_ref),     64'(e.alloc ? 1 : 0));
          chk("update_cnt",  64'(n_upd),     64'(e.wr ? 1 : 0));
          if (n_ref + n_upd > 0) chk("strobe_idx", 64'(strobe_idx), 64'(e.idx));
          chk("index_L2",    64'(bus.index_L2), 64'(e.idx));
          chk("hit_cnt",     64'(bus.hit_cnt),  64'(e.hcnt));
          chk("miss_cnt",    64'(bus.miss_cnt), 64'(e.mcnt));
          chk("rd_wr_overlap", 64'(both_hi),  64'd0);
          chk("addr_idle_nz",  64'(addr_stray), 64'd0);
        end
      end
    end
  end

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Issue one L1 request at a negedge; model decides the expected outcome.
  task automatic issue(input logic [63:0] a, input bit rd, input bit wr, input int d);
    exp_t       x;
    logic [7:0] idx;
    bit [49:0]  tg;
    bit         h;
    int         n;
    idx = a[13:6];
    tg  = a[63:14];
    h   = m_valid[idx] && (m_tag[idx] == tg);
    if (h) m_hit = sat_inc(m_hit); else m_miss = sat_inc(m_miss);
    x.wr         = wr;
    x.idx        = idx;
    x.wb         = !h && m_valid[idx] && m_dirty[idx];
    x.wb_addr    = {m_tag[idx], idx, 6'b0};
    x.alloc      = !h && !wr;
    x.alloc_addr = {tg, idx, 6'b0};
    x.lat        = (h && !wr) ? 2 : 3 + (x.wb ? d : 0) + (x.alloc ? d : 0);
    x.hcnt       = m_hit;
    x.mcnt       = m_miss;
    if (wr) begin
      m_tag[idx] = tg; m_valid[idx] = 1'b1; m_dirty[idx] = 1'b1;
    end else if (!h) begin
      m_tag[idx] = tg; m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0;
    end
    sb_q.push_back(x);
    mem_delay       = d;
    bus.addr_L1_L2  = a;
    bus.read_L1_L2  = rd;
    bus.write_L1_L2 = wr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ready_L2_L1 && n < 500);
    if (!bus.ready_L2_L1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: no ready_L2_L1 within 500 cycles for addr %0h", a);
      finish_run();
    end
    @(negedge clk);
    bus.read_L1_L2  = 1'b0;
    bus.write_L1_L2 = 1'b0;
  endtask

  initial begin
    int n;
    bus.addr_L1_L2  = '0;
    bus.read_L1_L2  = 1'b0;
    bus.write_L1_L2 = 1'b0;
    nrst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    chk_idle("reset");

    // Directed: cold read miss, repeat hit, write hit, dirty-victim read, both-ops-as-write
    issue(64'h0000_0000_0000_4040, 1, 0, 3);
    issue(64'h0000_0000_0000_4040, 1, 0, 1);
    issue(64'h0000_0000_0000_4040, 0, 1, 1);
    issue(64'h0000_0000_0000_8040, 1, 0, 2);
    issue(64'h0000_0000_0000_8080, 1, 1, 2);

    // Reset while waiting in ALLOCATE drops the request and empties the cache
    mem_delay       = 50;
    bus.addr_L1_L2  = 64'h0000_0000_0000_C040;
    bus.read_L1_L2  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.read_L2_MEM && n < 20);
    chk("alloc_before_reset", 64'(bus.read_L2_MEM), 64'd1);
    nrst           = 1'b1;
    bus.read_L1_L2 = 1'b0;
    @(negedge clk);
    nrst = 1'b0;
    model_reset();
    chk_idle("midop_reset");
    issue(64'h0000_0000_0000_C040, 1, 0, 2);

    // Random traffic over a few sets and tags so hits, misses and dirty victims mix
    mem_noise = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [63:0] a;
      int          op;
      a  = {50'($urandom_range(1, 4)), 8'($urandom_range(0, 3)), 6'($urandom)};
      op = $urandom_range(0, 3);
      issue(a, op != 2, op >= 2, $urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Miss counter saturation
    force dut.miss_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.miss_cnt_q;
    @(negedge clk);
    chk("miss_preload", 64'(bus.miss_cnt), 64'hFFFF_FFFF);
    m_miss = 32'hFFFF_FFFF;
    issue({50'h2_0000, 8'h10, 6'h00}, 1, 0, 2);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    finish_run();
  end

endmodule
